move_sequencer: RTL and testbench
=================================

# move_sequencer

Scripted move initiator for the Score 4 game core: accepts a target column over a valid/ready request port and drives the core's `left`, `right` and `put` button inputs as timed pulses. It steps the cursor to the target column, drops a piece, then watches `invalid_move`, `win_a`, `win_b` and `full_panel` to report an outcome code. It sits in front of the game top in place of the push-buttons. Typical uses are automated play and self-test.

## Interface
Parameters:
- `PULSE_LEN`, 2: cycles each button pulse is held high (1..255)
- `GAP_LEN`, 2: low cycles after every pulse (1..255)
- `SETTLE_LEN`, 4: cycles to watch `invalid_move` after the put gap (1..255)
- `START_COL`, 0: cursor column after reset (0..6)

Ports:
- `clk`  in  1  system clock; one clock domain
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  move request valid
- `req_col`  in  3  target column; 0..6 legal
- `req_ready`  out  1  high only in IDLE
- `left`  out  1  to game core `left`
- `right`  out  1  to game core `right`
- `put`  out  1  to game core `put`
- `invalid_move`  in  1  from game core
- `win_a`, `win_b`, `full_panel`  in  1 each  from game core
- `done`  out  1  one-cycle outcome strobe
- `resp_err`  out  2  outcome code; valid when `done`=1, holds its value otherwise. 0 ok, 1 illegal column, 2 invalid_move seen, 3 game over
- `cursor`  out  3  tracked cursor column

## Operation
- Cursor model: one `left` pulse decrements and one `right` pulse increments; the game core's cursor moves the same way. `put` leaves the cursor unchanged. The block never pulses past column 0 or 6.
- States: IDLE, CHECK, STEP_HI, STEP_LO, PUT_HI, PUT_LO, SETTLE, REPORT.
- IDLE:
  - `req_ready`=1.
  - When `req_valid`&`req_ready`, latch `req_col` as target and go to CHECK.
  - `req_col` is ignored at all other times.
- CHECK is 1 cycle. Conditions are evaluated in this priority order:
  1. Target > 6: error 1, go to REPORT.
  2. `win_a`|`win_b`|`full_panel`: error 3, go to REPORT.
  3. Target ≠ cursor: go to STEP_HI, direction is `left` if target < cursor, else `right`.
  4. Otherwise: go to PUT_HI.
- STEP_HI:
  - Drives the chosen button high for `PULSE_LEN` cycles.
  - The cursor updates by ±1 on the last cycle.
  - Then STEP_LO: all buttons low for `GAP_LEN` cycles, then back to CHECK.
- PUT_HI drives `put` for `PUT_LEN`=`PULSE_LEN` cycles. Then PUT_LO for `GAP_LEN` cycles, then SETTLE for `SETTLE_LEN` cycles.
- Error sticky: if `invalid_move`=1 on any cycle from the first PUT_HI cycle to the last SETTLE cycle, the code is 2. Otherwise it is 0.
- REPORT is 1 cycle: `done`=1 and `resp_err` carries the code. Then go to IDLE.
- At most one of `left`/`right`/`put` is high in any cycle, and no two pulses are adjacent (a gap of at least `GAP_LEN` always separates them).
- A game-over condition arising mid-move is caught at the next CHECK and aborts with error 3; no `put` is issued. A game-over condition during the put phase does not change the code.
- Counters are 8 bits, load `LEN-1` and count down to 0.

## Timing
- Reset values:
  - state IDLE; `left`=`right`=`put`=0
  - `done`=0, `resp_err`=0
  - `cursor`=`START_COL`, `req_ready`=1 in the cycle after `rst`
- `rst` asserted mid-operation aborts immediately: no `done` and no further pulses.
- Outputs are registered.
- Let the accept edge be cycle 0, and let d = |target − cursor|:
  - CHECK at cycle 1.
  - Each step costs `PULSE_LEN`+`GAP_LEN`+1 cycles.
  - `done` at cycle 1 + d·(`PULSE_LEN`+`GAP_LEN`+1) + `PULSE_LEN` + `GAP_LEN` + `SETTLE_LEN` + 1.
- Error 1 or 3 detected at the first CHECK gives `done` at cycle 2.
- `req_ready` deasserts the cycle after accept and reasserts the cycle after `done`. A new request can be accepted in the cycle `req_ready` returns high.

## Test plan
- Defaults, cursor 0, `req_col`=0: `put` high in cycles 2–3, no `left`/`right`, `done` at cycle 10 with `resp_err`=0.
- Defaults, cursor 0, `req_col`=3: three `right` pulses starting at cycles 2, 7, 12, then `put` at 17–18. `done` at cycle 25 with `resp_err`=0 and `cursor`=3. A follow-up `req_col`=1 gives two `left` pulses.
- `req_col`=7: no pulses, `done` at cycle 2 with `resp_err`=1, cursor unchanged.
- `win_b` held high, `req_col`=2 → `done` at cycle 2 with `resp_err`=3. With `full_panel` rising during the second step of a 0→3 move: abort at the next CHECK, `cursor`=2, `resp_err`=3, `put` never asserted.
- `invalid_move` pulsed for one cycle in SETTLE → `resp_err`=2 at the normal `done` time.
- `rst` asserted during PUT_HI: next cycle all buttons are 0, `done` never fires, `cursor`=`START_COL`, `req_ready`=1.

Source files
------------

// File: rtl/move_sequencer.sv
// move_sequencer: scripted move initiator for the Score 4 core.
// Steps the cursor to a target column, drops a piece, reports outcome.
module move_sequencer #(
   parameter int PULSE_LEN  = 2,
   parameter int GAP_LEN    = 2,
   parameter int SETTLE_LEN = 4,
   parameter int START_COL  = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic [2:0] req_col,
   output logic       req_ready,
   output logic       left,
   output logic       right,
   output logic       put,
   input  logic       invalid_move,
   input  logic       win_a,
   input  logic       win_b,
   input  logic       full_panel,
   output logic       done,
   output logic [1:0] resp_err,
   output logic [2:0] cursor
);

   localparam logic [7:0] PULSE_M1  = 8'(PULSE_LEN - 1);
   localparam logic [7:0] GAP_M1    = 8'(GAP_LEN - 1);
   localparam logic [7:0] SETTLE_M1 = 8'(SETTLE_LEN - 1);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      STEP_HI,
      STEP_LO,
      PUT_HI,
      PUT_LO,
      SETTLE,
      REPORT
   } state_t;

   state_t     state, state_n;
   logic [7:0] cnt, cnt_n;
   logic [2:0] target, target_n;
   logic [2:0] cursor_n;
   logic       dir_left, dir_left_n;
   logic       inv_seen, inv_seen_n;
   logic [1:0] code_n;
   logic       game_over;

   assign game_over = win_a | win_b | full_panel;

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      target_n   = target;
      cursor_n   = cursor;
      dir_left_n = dir_left;
      inv_seen_n = inv_seen;
      code_n     = resp_err;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               target_n = req_col;
               state_n  = CHECK;
            end
         end
         CHECK: begin
            inv_seen_n = 1'b0;
            if (target > 3'd6) begin
               code_n  = 2'd1;
               state_n = REPORT;
            end else if (game_over) begin
               code_n  = 2'd3;
               state_n = REPORT;
            end else if (target != cursor) begin
               dir_left_n = (target < cursor);
               cnt_n      = PULSE_M1;
               state_n    = STEP_HI;
            end else begin
               cnt_n   = PULSE_M1;
               state_n = PUT_HI;
            end
         end
         STEP_HI: begin
            if (cnt == 8'd0) begin
               cursor_n = dir_left ? cursor - 3'd1
                                   : cursor + 3'd1;
               cnt_n    = GAP_M1;
               state_n  = STEP_LO;
            end else begin
               cnt_n = cnt - 8'd1;
            end
         end
         STEP_LO: begin
            if (cnt == 8'd0) state_n = CHECK;
            else cnt_n = cnt - 8'd1;
         end
         PUT_HI: begin
            inv_seen_n = inv_seen | invalid_move;
            if (cnt == 8'd0) begin
               cnt_n   = GAP_M1;
               state_n = PUT_LO;
            end else begin
               cnt_n = cnt - 8'd1;
            end
         end
         PUT_LO: begin
            inv_seen_n = inv_seen | invalid_move;
            if (cnt == 8'd0) begin
               cnt_n   = SETTLE_M1;
               state_n = SETTLE;
            end else begin
               cnt_n = cnt - 8'd1;
            end
         end
         SETTLE: begin
            inv_seen_n = inv_seen | invalid_move;
            if (cnt == 8'd0) begin
               code_n  = inv_seen_n ? 2'd2 : 2'd0;
               state_n = REPORT;
            end else begin
               cnt_n = cnt - 8'd1;
            end
         end
         REPORT: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 8'd0;
         target   <= 3'd0;
         dir_left <= 1'b0;
         inv_seen <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         target   <= target_n;
         dir_left <= dir_left_n;
         inv_seen <= inv_seen_n;
      end
   end

   // Outputs are registered from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         left      <= 1'b0;
         right     <= 1'b0;
         put       <= 1'b0;
         done      <= 1'b0;
         resp_err  <= 2'd0;
         req_ready <= 1'b1;
         cursor    <= 3'(START_COL);
      end else begin
         left      <= (state_n == STEP_HI) & dir_left_n;
         right     <= (state_n == STEP_HI) & ~dir_left_n;
         put       <= (state_n == PUT_HI);
         done      <= (state_n == REPORT);
         resp_err  <= code_n;
         req_ready <= (state_n == IDLE);
         cursor    <= cursor_n;
      end
   end

endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: randomized self-checking bench for move_sequencer.
// Expected pulse timelines come from a cycle-arithmetic model.
module tb_move_sequencer;

   localparam int P  = 2;
   localparam int G  = 2;
   localparam int S  = 4;
   localparam int SC = 0;
   localparam int ST = P + G + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req_valid = 1'b0;
   logic [2:0] req_col = 3'd0;
   logic       req_ready;
   logic       left, right, put;
   logic       invalid_move = 1'b0;
   logic       win_a = 1'b0;
   logic       win_b = 1'b0;
   logic       full_panel = 1'b0;
   logic       done;
   logic [1:0] resp_err;
   logic [2:0] cursor;

   int checks = 0;
   int failures = 0;
   int m_cur = SC;

   move_sequencer #(
      .PULSE_LEN(P), .GAP_LEN(G),
      .SETTLE_LEN(S), .START_COL(SC)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_col(req_col),
      .req_ready(req_ready),
      .left(left), .right(right), .put(put),
      .invalid_move(invalid_move),
      .win_a(win_a), .win_b(win_b),
      .full_panel(full_panel),
      .done(done), .resp_err(resp_err),
      .cursor(cursor)
   );

   always #5 clk = ~clk;

   task automatic set_go(input int which, input logic val);
      win_a = 1'b0;
      win_b = 1'b0;
      full_panel = 1'b0;
      case (which)
         0: win_a = val;
         1: win_b = val;
         default: full_panel = val;
      endcase
   endtask

   // g: first cycle game-over is held (-1 none); v: invalid pulse cycle.
   task automatic run_move(input int col, input int g,
                           input int v, input int which,
                           input string tag);
      int w, d, done_c, code, steps, ps, se;
      bit dl, aborted;
      logic [3:0] exp_v, got_v;
      w = 0;
      while (req_ready !== 1'b1 && w < 60) begin
         @(posedge clk); #1; w++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s ready_wait got=%b want=1", tag, req_ready);
      end
      req_valid = 1'b1;
      req_col = 3'(col);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_col = 3'($urandom_range(0, 7));
      steps = 0; aborted = 0; ps = -1;
      dl = (col < m_cur);
      d = dl ? m_cur - col : col - m_cur;
      if (col > 6) begin
         code = 1; done_c = 2;
      end else begin
         code = 0; done_c = 0;
         for (int i = 0; i <= d; i++) begin
            if (!aborted && g >= 0 && 1 + ST * i >= g) begin
               aborted = 1; steps = i;
               code = 3; done_c = 2 + ST * i;
            end
         end
         if (!aborted) begin
            steps = d;
            ps = 2 + ST * d;
            se = ps + P + G + S - 1;
            done_c = se + 1;
            code = (v >= ps && v <= se) ? 2 : 0;
         end
      end
      for (int k = 1; k <= done_c; k++) begin
         set_go(which, g >= 0 && k >= g);
         invalid_move = (k == v);
         exp_v = 4'b0;
         for (int j = 0; j < steps; j++)
            if (k >= 2 + ST * j && k <= 1 + ST * j + P)
               exp_v[dl ? 3 : 2] = 1'b1;
         if (ps >= 0 && k >= ps && k < ps + P) exp_v[1] = 1'b1;
         if (k == done_c) exp_v[0] = 1'b1;
         got_v = {left, right, put, done};
         checks++;
         if (got_v !== exp_v || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s cyc%0d lrpd=%b rdy=%b want lrpd=%b rdy=0",
                     tag, k, got_v, req_ready, exp_v);
         end
         if (k == done_c) begin
            checks++;
            if (resp_err !== 2'(code)) begin
               failures++;
               $display("FAIL %s resp_err got=%0d want=%0d",
                        tag, resp_err, code);
            end
         end
         @(posedge clk); #1;
      end
      set_go(which, 1'b0);
      invalid_move = 1'b0;
      if (col <= 6) m_cur = dl ? m_cur - steps : m_cur + steps;
      checks++;
      if (req_ready !== 1'b1 || done !== 1'b0 ||
          cursor !== 3'(m_cur) || resp_err !== 2'(code)) begin
         failures++;
         $display("FAIL %s after rdy=%b done=%b cur=%0d err=%0d want 1 0 %0d %0d",
                  tag, req_ready, done, cursor, resp_err, m_cur, code);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({left, right, put, done} !== 4'b0 || resp_err !== 2'd0 ||
          cursor !== 3'(SC) || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset lrpd=%b err=%0d cur=%0d rdy=%b want 0000 0 %0d 1",
                  {left, right, put, done}, resp_err, cursor, req_ready, SC);
      end
      rst = 1'b0;
      m_cur = SC;
   endtask

   task automatic test_put_only;
      run_move(m_cur, -1, -1, 0, "put_only");
   endtask

   task automatic test_steps;
      run_move(3, -1, -1, 0, "step_right");
      run_move(1, -1, -1, 0, "step_left");
   endtask

   task automatic test_illegal;
      run_move(7, -1, -1, 0, "illegal");
   endtask

   task automatic test_game_over;
      run_move(2, 1, -1, 1, "win_b_held");
      test_reset();
      run_move(3, 7, -1, 2, "full_mid");
      checks++;
      if (cursor !== 3'd2) begin
         failures++;
         $display("FAIL full_mid_cursor got=%0d want=2", cursor);
      end
   endtask

   task automatic test_invalid;
      int d;
      d = (m_cur > 4) ? m_cur - 4 : 4 - m_cur;
      run_move(4, -1, 2 + ST * d + P + G + 1, 0, "inv_settle");
      run_move(5, -1, 2, 0, "inv_in_step");
   endtask

   task automatic test_back_to_back;
      int col, g, v, d;
      for (int n = 0; n < 30; n++) begin
         col = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 6);
         d = (col > m_cur) ? col - m_cur : m_cur - col;
         g = ($urandom_range(0, 4) == 0) ?
             $urandom_range(1, 1 + ST * d) : -1;
         v = ($urandom_range(0, 2) == 0) ?
             $urandom_range(1, 2 + ST * d + P + G + S) : -1;
         run_move(col, g, v, $urandom_range(0, 2), "random");
      end
   endtask

   task automatic test_rst_mid;
      int d, ps;
      d = (m_cur > 2) ? m_cur - 2 : 2 - m_cur;
      ps = 2 + ST * d;
      req_valid = 1'b1;
      req_col = 3'd2;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int k = 1; k < ps; k++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (put !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_put got=%b want=1", put);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_cur = SC;
      checks++;
      if ({left, right, put, done} !== 4'b0 ||
          cursor !== 3'(SC) || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid lrpd=%b cur=%0d rdy=%b want 0000 %0d 1",
                  {left, right, put, done}, cursor, req_ready, SC);
      end
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         checks++;
         if ({left, right, put, done} !== 4'b0) begin
            failures++;
            $display("FAIL rst_mid_quiet cyc%0d lrpd=%b want 0000",
                     k, {left, right, put, done});
         end
      end
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_put_only();
      test_steps();
      test_illegal();
      test_game_over();
      test_invalid();
      test_back_to_back();
      test_rst_mid();
      run_move(1, -1, -1, 0, "post_rst");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
